// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD card engines (init, sector read, read
// scheduler): state encodings, picture layout constants and the helper that
// turns a picture index into its starting sector.
// -----------------------------------------------------------------------------
package sd_pkg;

    // Read scheduler states; the encoding is exported on the debug port.
    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_GAP       = 3'd4,
        ST_THROTTLE  = 3'd5,
        ST_ERR       = 3'd6
    } sd_state_e;

    // Start sector of picture 0 on the card.
    localparam logic [31:0] SD_SADDR   = 32'd197184;
    // Sectors per picture: 1024 x 768 x 2 bytes / 512 bytes per sector.
    localparam logic [11:0] SD_SEC_LEN = 12'd3072;
    // Number of pictures stored back to back.
    localparam int          SD_PIC_NUM = 4;

    // First sector of picture `sel`. The scheduler always calls this with
    // constant saddr/sec_len, so the multiply folds into a small constant mux.
    function automatic logic [31:0] sd_pic_base(
        input logic [31:0] saddr,
        input logic [11:0] sec_len,
        input logic [1:0]  sel
    );
        logic [31:0] w_prod;
        w_prod = {30'd0, sel} * {20'd0, sec_len};
        return saddr + w_prod;
    endfunction

endpackage

// File: rtl/sd_read_scheduler.sv
// -----------------------------------------------------------------------------
// sd_read_scheduler
// Sequences the sector reads that move one stored picture from the SD card
// into the DDR write FIFO. After the init engine reports done it owns the SPI
// lines (through the sector-read engine), issues one sector request at a time,
// waits for the sector to complete (with a timeout), leaves SD_cs high for a
// short gap between sectors and backs off while the downstream FIFO is almost
// full.
//
// Ports
//   SD_clk, rst             clock, asynchronous active-high reset
//   init_done               init engine finished (level); falling aborts
//   init_cs, init_datain    SPI drive from the init engine
//   rd_cs, rd_datain        SPI drive from the sector-read engine
//   SD_cs, SD_datain        registered, muxed SPI drive to the card
//   pic_req, pic_sel        one-cycle request to load picture pic_sel
//   fifo_afull              downstream FIFO almost full (throttle)
//   sec_req, sec_addr       one-cycle sector request and its address
//   sec_done                one-cycle pulse: sector delivered
//   busy                    picture transfer in progress
//   pic_done                one-cycle pulse: last sector of picture done
//   err                     sticky sector-timeout flag
//   state                   current FSM state (debug)
// -----------------------------------------------------------------------------
module sd_read_scheduler
    import sd_pkg::*;
#(
    parameter logic [31:0] SADDR   = SD_SADDR,
    parameter logic [11:0] SEC_LEN = SD_SEC_LEN,
    parameter int          PIC_NUM = SD_PIC_NUM,
    parameter int          GAP_CYC = 16,
    parameter logic [15:0] TMO_CYC = 16'd65535
) (
    input  logic        SD_clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        init_cs,
    input  logic        init_datain,
    input  logic        rd_cs,
    input  logic        rd_datain,
    output logic        SD_cs,
    output logic        SD_datain,
    input  logic        pic_req,
    input  logic [1:0]  pic_sel,
    input  logic        fifo_afull,
    output logic        sec_req,
    output logic [31:0] sec_addr,
    input  logic        sec_done,
    output logic        busy,
    output logic        pic_done,
    output logic        err,
    output logic [2:0]  state
);

    localparam logic [31:0] PIC_NUM_U = 32'(PIC_NUM);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [15:0] TMO_LAST  = TMO_CYC - 16'd1;
    localparam logic [11:0] SEC_LAST  = SEC_LEN - 12'd1;

    // Registered state and outputs
    sd_state_e   r_state;
    logic        r_sd_cs;
    logic        r_sd_datain;
    logic        r_sec_req;
    logic [31:0] r_sec_addr;
    logic [11:0] r_sec_cnt;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_gap_cnt;
    logic        r_busy;
    logic        r_pic_done;
    logic        r_err;

    // Next-state values
    sd_state_e   w_state_nxt;
    logic        w_sd_cs_nxt;
    logic        w_sd_datain_nxt;
    logic        w_sec_req_nxt;
    logic [31:0] w_sec_addr_nxt;
    logic [11:0] w_sec_cnt_nxt;
    logic [15:0] w_tmo_cnt_nxt;
    logic [15:0] w_gap_cnt_nxt;
    logic        w_busy_nxt;
    logic        w_pic_done_nxt;
    logic        w_err_nxt;

    logic        w_sel_ok;
    logic        w_abort;

    assign w_sel_ok = ({30'd0, pic_sel} < PIC_NUM_U);

    // Losing init_done drops back to WAIT_INIT from any working state. ERR is
    // excluded so a timeout stays latched until reset.
    assign w_abort = !init_done && (r_state != ST_WAIT_INIT) && (r_state != ST_ERR);

    // Next-state and next-output logic of the scheduler FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_sec_req_nxt  = 1'b0;
        w_sec_addr_nxt = r_sec_addr;
        w_sec_cnt_nxt  = r_sec_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_busy_nxt     = r_busy;
        w_pic_done_nxt = 1'b0;
        w_err_nxt      = r_err;

        if (w_abort) begin
            // Current picture is discarded; no pic_done.
            w_state_nxt = ST_WAIT_INIT;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_INIT: begin
                    if (init_done) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_INIT;
                    end
                end

                ST_IDLE: begin
                    if (pic_req && w_sel_ok) begin
                        w_sec_addr_nxt = sd_pic_base(SADDR, SEC_LEN, pic_sel);
                        w_sec_cnt_nxt  = 12'd0;
                        w_busy_nxt     = 1'b1;
                        w_state_nxt    = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    if (fifo_afull) begin
                        w_state_nxt = ST_THROTTLE;
                    end else begin
                        w_sec_req_nxt = 1'b1;
                        w_tmo_cnt_nxt = 16'd0;
                        w_state_nxt   = ST_WAIT;
                    end
                end

                ST_THROTTLE: begin
                    if (!fifo_afull) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_THROTTLE;
                    end
                end

                ST_WAIT: begin
                    // sec_done is checked first so it wins over a timeout
                    // reached in the same cycle.
                    if (sec_done) begin
                        w_gap_cnt_nxt = 16'd0;
                        w_state_nxt   = ST_GAP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt != GAP_LAST) begin
                        w_gap_cnt_nxt = r_gap_cnt + 16'd1;
                    end else if (r_sec_cnt == SEC_LAST) begin
                        w_pic_done_nxt = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_sec_addr_nxt = r_sec_addr + 32'd1;
                        w_sec_cnt_nxt  = r_sec_cnt + 12'd1;
                        w_state_nxt    = ST_ISSUE;
                    end
                end

                ST_ERR: begin
                    w_state_nxt = ST_ERR;
                end

                default: begin
                    w_state_nxt = ST_WAIT_INIT;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // SPI mux, keyed on the next state so the registered lines line up with
    // the registered state (SD_cs is already high in the first GAP cycle).
    always_comb begin
        w_sd_cs_nxt     = 1'b1;
        w_sd_datain_nxt = 1'b1;
        case (w_state_nxt)
            ST_WAIT_INIT: begin
                w_sd_cs_nxt     = init_cs;
                w_sd_datain_nxt = init_datain;
            end
            ST_GAP, ST_ERR: begin
                w_sd_cs_nxt     = 1'b1;
                w_sd_datain_nxt = 1'b1;
            end
            default: begin
                w_sd_cs_nxt     = rd_cs;
                w_sd_datain_nxt = rd_datain;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_WAIT_INIT;
            r_sd_cs     <= 1'b1;
            r_sd_datain <= 1'b1;
            r_sec_req   <= 1'b0;
            r_sec_addr  <= SADDR;
            r_sec_cnt   <= 12'd0;
            r_tmo_cnt   <= 16'd0;
            r_gap_cnt   <= 16'd0;
            r_busy      <= 1'b0;
            r_pic_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sd_cs     <= w_sd_cs_nxt;
            r_sd_datain <= w_sd_datain_nxt;
            r_sec_req   <= w_sec_req_nxt;
            r_sec_addr  <= w_sec_addr_nxt;
            r_sec_cnt   <= w_sec_cnt_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_pic_done  <= w_pic_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign SD_cs     = r_sd_cs;
    assign SD_datain = r_sd_datain;
    assign sec_req   = r_sec_req;
    assign sec_addr  = r_sec_addr;
    assign busy      = r_busy;
    assign pic_done  = r_pic_done;
    assign err       = r_err;
    assign state     = r_state;

endmodule
